// File: rtl/iterative_divider16_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

   localparam int DIV_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      FIXUP  = 2'd2,
      DONE   = 2'd3
   } div_state_t;

   // Unsigned magnitude of an operand: two's-complement negate only when the
   // operand is signed and negative. 0x8000 maps to itself (read as unsigned).
   function automatic logic [DIV_W-1:0] abs_mag(input logic [DIV_W-1:0] value,
                                                input logic             signedFlag);
      if (signedFlag && value[DIV_W-1])
         abs_mag = ~value + 1'b1;
      else
         abs_mag = value;
   endfunction

endpackage

// File: rtl/iterative_divider16_if.sv
// Start/done handshake and result bus between the execute stage and the divider.
interface iterative_divider16_if
   import div_pkg::*;
#(
   parameter int M = DIV_W
);
   logic         start;
   logic         signedFlag;
   logic [M-1:0] dividend;
   logic [M-1:0] divisor;
   logic         busy;
   logic         done;
   logic [M-1:0] quotient;
   logic [M-1:0] remainder;
   logic         divByZero;

   // Requester side (execute stage).
   modport master (
      output start, signedFlag, dividend, divisor,
      input  busy, done, quotient, remainder, divByZero
   );

   // Divider side.
   modport slave (
      input  start, signedFlag, dividend, divisor,
      output busy, done, quotient, remainder, divByZero
   );
endinterface

// File: rtl/iterative_divider16_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the
// divisor magnitude, keep the difference and set the quotient bit if it fits.
module div_step
   import div_pkg::*;
#(
   parameter int M = DIV_W
) (
   input  logic [M:0]   r_in,
   input  logic [M-1:0] q_in,
   input  logic [M-1:0] dmag,
   output logic [M:0]   r_out,
   output logic [M-1:0] q_out
);

   logic [M+1:0] shifted_r;
   logic [M+1:0] diff;

   // Partial remainder stays below the divisor, so the shifted value fits in
   // M+1 bits and the top bit of the M+2-bit difference is a clean sign bit.
   always_comb begin
      shifted_r = {r_in, q_in[M-1]};
      diff      = shifted_r - {2'b00, dmag};
      if (!diff[M+1]) begin
         r_out = diff[M:0];
         q_out = {q_in[M-2:0], 1'b1};
      end else begin
         r_out = shifted_r[M:0];
         q_out = {q_in[M-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/iterative_divider16.sv
// Multi-cycle restoring divider, one quotient bit per cycle, signed or
// unsigned, with a start/done handshake. Not pipelined: a new request is
// only taken in IDLE.
module iterative_divider16
   import div_pkg::*;
#(
   parameter int M = DIV_W
) (
   input  logic                  clk,
   input  logic                  rst,
   iterative_divider16_if.slave  bus
);

   localparam int               CW   = $clog2(M);
   localparam logic [CW-1:0]    LAST = CW'(M - 1);

   div_state_t   state_reg, state_next;
   logic [CW-1:0] cnt_reg;
   logic [M:0]    r_reg;
   logic [M-1:0]  q_reg;
   logic [M-1:0]  dmag_reg;
   logic          qneg_reg;
   logic          rneg_reg;
   logic [M-1:0]  quotient_reg;
   logic [M-1:0]  remainder_reg;
   logic          dbz_reg;

   logic [M:0]    r_step;
   logic [M-1:0]  q_step;
   logic          busy_now;
   logic          done_now;
   logic          accept;
   logic          zero_div;

   assign accept   = (state_reg == IDLE) && bus.start;
   assign zero_div = (bus.divisor == '0);

   div_step #(.M(M)) u_step (
      .r_in  (r_step_src_r()),
      .q_in  (q_reg),
      .dmag  (dmag_reg),
      .r_out (r_step),
      .q_out (q_step)
   );

   function automatic logic [M:0] r_step_src_r();
      return r_reg;
   endfunction

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_next = state_reg;
      busy_now   = 1'b0;
      done_now   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start)
               state_next = zero_div ? DONE : DIVIDE;
         end
         DIVIDE: begin
            busy_now = 1'b1;
            if (cnt_reg == LAST)
               state_next = FIXUP;
         end
         FIXUP: begin
            busy_now   = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            done_now   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, iteration datapath and result registers. Results only
   // move on the divide-by-zero shortcut, in FIXUP, and on reset, so they are
   // held stable between operations.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg       <= '0;
         r_reg         <= '0;
         q_reg         <= '0;
         dmag_reg      <= '0;
         qneg_reg      <= 1'b0;
         rneg_reg      <= 1'b0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dbz_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  q_reg    <= abs_mag(bus.dividend, bus.signedFlag);
                  dmag_reg <= abs_mag(bus.divisor, bus.signedFlag);
                  qneg_reg <= bus.signedFlag & (bus.dividend[M-1] ^ bus.divisor[M-1]);
                  rneg_reg <= bus.signedFlag & bus.dividend[M-1];
                  r_reg    <= '0;
                  cnt_reg  <= '0;
                  if (zero_div) begin
                     quotient_reg  <= '1;
                     remainder_reg <= bus.dividend;
                     dbz_reg       <= 1'b1;
                  end
               end
            end
            DIVIDE: begin
               r_reg   <= r_step;
               q_reg   <= q_step;
               cnt_reg <= cnt_reg + 1'b1;
            end
            FIXUP: begin
               // Signs are restored mod 2^M; -0x8000 wraps to 0x8000 naturally.
               quotient_reg  <= qneg_reg ? (~q_reg + 1'b1) : q_reg;
               remainder_reg <= rneg_reg ? (~r_reg[M-1:0] + 1'b1) : r_reg[M-1:0];
               dbz_reg       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = busy_now;
   assign bus.done      = done_now;
   assign bus.quotient  = quotient_reg;
   assign bus.remainder = remainder_reg;
   assign bus.divByZero = dbz_reg;

endmodule
